// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and helpers for the parameterised data pipeline.
//   DEFAULT_*      : default data width, stage count and match set
//   total_offset() : total increment a beat picks up across all stages
package pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 8;
    localparam int unsigned DEFAULT_DEPTH      = 4;
    localparam int unsigned DEFAULT_MATCH_BITS = 3;
    localparam logic [2:0]  DEFAULT_MATCH_A    = 3'b101;
    localparam logic [2:0]  DEFAULT_MATCH_B    = 3'b111;

    // Stage i adds i, so a beat leaving the last stage carries sum(0..DEPTH-1).
    function automatic int unsigned total_offset(input int unsigned depth);
        return (depth * (depth - 1)) / 2;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one pipeline stage (data register, valid bit, add-by-constant).
//   clk, rst_n    : clock, asynchronous active-low reset
//   advance_i     : stage may take a new beat (its current beat, if any, leaves)
//   flush_i       : clear valid bit, keep data
//   prev_valid_i  : upstream stage (or input port) holds a beat
//   prev_data_i   : upstream data
//   valid_d_o     : next-state valid bit (used for registered occupancy)
//   valid_q_o     : current valid bit
//   data_q_o      : current data
module pipe_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned INCR  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance_i,
    input  logic             flush_i,
    input  logic             prev_valid_i,
    input  logic [WIDTH-1:0] prev_data_i,
    output logic             valid_d_o,
    output logic             valid_q_o,
    output logic [WIDTH-1:0] data_q_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            // Flush drops beats but leaves data registers untouched.
            valid_d = 1'b0;
        end else if (advance_i) begin
            valid_d = prev_valid_i;
            if (prev_valid_i) begin
                data_d = prev_data_i + WIDTH'(INCR);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_d_o = valid_d;
    assign valid_q_o = valid_q;
    assign data_q_o  = data_q;

endmodule

// File: rtl/param_data_pipeline.sv
// param_data_pipeline: DEPTH-stage valid/ready pipeline; stage i adds i to the
// beat, so output = input + DEPTH*(DEPTH-1)/2. Full throughput, no bubbles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data the upstream beat
//   out_valid/out_ready : downstream handshake, out_data the last-stage beat
//   out_match           : low MATCH_BITS of out_data hit MATCH_A or MATCH_B
//   flush               : synchronous discard of all in-flight beats
//   occupancy           : registered count of valid stages
module param_data_pipeline
    import pipe_pkg::*;
#(
    parameter int unsigned            WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned            DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned            MATCH_BITS = DEFAULT_MATCH_BITS,
    parameter logic [MATCH_BITS-1:0]  MATCH_A    = MATCH_BITS'(DEFAULT_MATCH_A),
    parameter logic [MATCH_BITS-1:0]  MATCH_B    = MATCH_BITS'(DEFAULT_MATCH_B),
    localparam int unsigned           OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_match,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] advance;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;

    // Ready ripples back from the output: a stage may advance if the next
    // stage is empty or itself advancing. Computed in one process, last stage
    // first, so the chain stays a simple combinational ladder.
    always_comb begin
        advance = '0;
        advance[DEPTH-1] = out_ready | ~valid_q[DEPTH-1];
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            advance[i] = ~valid_q[i+1] | advance[i+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(DEPTH); gi++) begin : g_stage
            logic             prev_valid;
            logic [WIDTH-1:0] prev_data;
            if (gi == 0) begin : g_head
                assign prev_valid = in_valid;
                assign prev_data  = in_data;
            end else begin : g_body
                assign prev_valid = valid_q[gi-1];
                assign prev_data  = data_q[gi-1];
            end

            pipe_stage #(
                .WIDTH (WIDTH),
                .INCR  (gi)
            ) u_stage (
                .clk          (clk),
                .rst_n        (rst_n),
                .advance_i    (advance[gi]),
                .flush_i      (flush),
                .prev_valid_i (prev_valid),
                .prev_data_i  (prev_data),
                .valid_d_o    (valid_d[gi]),
                .valid_q_o    (valid_q[gi]),
                .data_q_o     (data_q[gi])
            );
        end
    endgenerate

    // Occupancy is the popcount of the next-state valid bits, registered so
    // it tracks the valid bits exactly after every edge.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_ready  = advance[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_match = valid_q[DEPTH-1] &&
                       ((out_data[MATCH_BITS-1:0] == MATCH_A) ||
                        (out_data[MATCH_BITS-1:0] == MATCH_B));
    assign occupancy = occ_q;

endmodule

// File: tb/tb_param_data_pipeline.sv
// tb_param_data_pipeline: scoreboard bench for param_data_pipeline.
// Instance A uses defaults (WIDTH=8, DEPTH=4); instance B uses WIDTH=16, DEPTH=6.
module tb_param_data_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A (defaults)
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_match, a_flush;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_occ;

    // Instance B (WIDTH=16, DEPTH=6)
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_match, b_flush;
    logic [15:0] b_in_data, b_out_data;
    logic [2:0]  b_occ;

    param_data_pipeline u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_match (a_out_match),
        .flush     (a_flush),
        .occupancy (a_occ)
    );

    param_data_pipeline #(
        .WIDTH (16),
        .DEPTH (6)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_match (b_out_match),
        .flush     (b_flush),
        .occupancy (b_occ)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic match8(input logic [7:0] v);
        return (v[2:0] == 3'b101) || (v[2:0] == 3'b111);
    endfunction

    // Scoreboard for instance A: push input+6 on accept, pop on emit.
    logic [7:0] exp_a [$];
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_out_valid && a_out_ready) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_out", {24'h0, a_out_data}, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_a.pop_front();
                    $display("txn A out data=0x%02h match=%0d exp=0x%02h", a_out_data, a_out_match, mon_exp);
                    chk("a_out_data", {24'h0, a_out_data}, {24'h0, mon_exp});
                    chk("a_out_match", {31'h0, a_out_match}, {31'h0, match8(mon_exp)});
                end
            end
            if (a_flush) begin
                exp_a.delete();
            end else if (a_in_valid && a_in_ready) begin
                $display("txn A in  data=0x%02h", a_in_data);
                exp_a.push_back(a_in_data + 8'd6);
            end
        end
    end

    task automatic drain_a(input string tag);
        int c = 0;
        while ((exp_a.size() != 0 || a_out_valid) && c < 100) begin
            tick();
            c++;
        end
        chk(tag, 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        logic acc;

        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid  = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_flush = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'h0, a_in_ready},  32'd1);
        chk("rst_out_valid", {31'h0, a_out_valid}, 32'd0);
        chk("rst_out_data",  {24'h0, a_out_data},  32'd0);
        chk("rst_out_match", {31'h0, a_out_match}, 32'd0);
        chk("rst_occ",       {29'h0, a_occ},       32'd0);
        chk("rst_b_in_ready",{31'h0, b_in_ready},  32'd1);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'h0, a_in_ready}, 32'd1);

        // Single beat latency: accepted at edge N, visible after N+3
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1; a_in_data = 8'h10;
        tick();
        a_in_valid  = 1'b0;
        chk("t1_occ_after_accept", {29'h0, a_occ}, 32'd1);
        tick();
        tick();
        chk("t1_not_early", {31'h0, a_out_valid}, 32'd0);
        tick();
        chk("t1_out_valid", {31'h0, a_out_valid}, 32'd1);
        chk("t1_out_data",  {24'h0, a_out_data},  32'h16);
        chk("t1_occ_last",  {29'h0, a_occ},       32'd1);
        tick();
        chk("t1_occ_empty", {29'h0, a_occ},       32'd0);
        chk("t1_valid_gone",{31'h0, a_out_valid}, 32'd0);

        // Wrap-around and match
        a_in_valid = 1'b1; a_in_data = 8'hFF;
        tick();
        a_in_data = 8'hFE;
        tick();
        a_in_valid = 1'b0;
        drain_a("t2_drain");

        // Back-to-back stream with downstream stall until full
        a_out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(sent);
            if (c == 8) a_out_ready = 1'b1;
            #1;
            if (c == 6) begin
                chk("t3_full_in_ready", {31'h0, a_in_ready}, 32'd0);
                chk("t3_full_occ",      {29'h0, a_occ},      32'd4);
            end
            acc = a_in_valid && a_in_ready;
            tick();
            if (acc) sent++;
        end
        a_in_valid = 1'b0;
        chk("t3_all_sent", 32'(sent), 32'd8);
        drain_a("t3_drain");

        // Flush with the pipeline full
        a_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 1'b1; a_in_data = 8'(8'h20 + k);
            tick();
        end
        chk("t4_full_occ", {29'h0, a_occ}, 32'd4);
        a_in_valid = 1'b1; a_in_data = 8'h55; a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("t4_flush_occ",   {29'h0, a_occ},       32'd0);
        chk("t4_flush_valid", {31'h0, a_out_valid}, 32'd0);

        // Flush wins over a same-cycle accept when in_ready=1
        a_in_valid = 1'b1; a_in_data = 8'h60; tick();
        a_in_data = 8'h61; tick();
        a_in_data = 8'h77; a_flush = 1'b1;
        #1;
        chk("t4b_in_ready", {31'h0, a_in_ready}, 32'd1);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("t4b_flush_occ", {29'h0, a_occ}, 32'd0);
        a_out_ready = 1'b1;
        repeat (6) tick();
        chk("t4b_no_emit", {31'h0, a_out_valid}, 32'd0);

        // Reset mid-stream with three beats in flight
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1; a_in_data = 8'(8'h30 + k);
            tick();
        end
        a_in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        exp_a.delete();
        #1;
        chk("t5_rst_valid", {31'h0, a_out_valid}, 32'd0);
        chk("t5_rst_occ",   {29'h0, a_occ},       32'd0);
        chk("t5_rst_data",  {24'h0, a_out_data},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t5_in_ready", {31'h0, a_in_ready}, 32'd1);
        repeat (8) tick();
        chk("t5_no_stale", {31'h0, a_out_valid}, 32'd0);
        a_in_valid = 1'b1; a_in_data = 8'h40;
        tick();
        a_in_valid = 1'b0;
        drain_a("t5_drain");

        // Wide/deep instance: 0xFFF8 + 15 wraps to 0x0007
        b_in_valid = 1'b1; b_in_data = 16'hFFF8;
        tick();
        b_in_valid = 1'b0;
        repeat (4) tick();
        chk("t6_not_early", {31'h0, b_out_valid}, 32'd0);
        tick();
        $display("txn B out data=0x%04h match=%0d", b_out_data, b_out_match);
        chk("t6_out_valid", {31'h0, b_out_valid}, 32'd1);
        chk("t6_out_data",  {16'h0, b_out_data},  32'h0007);
        chk("t6_out_match", {31'h0, b_out_match}, 32'd1);
        tick();
        chk("t6_occ_empty", {29'h0, b_occ}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
